load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits in the MEM stage between the EX/MEM pipeline register and the word-addressed data memory.
- Adds byte and halfword loads and stores (lb, lbu, lh, lhu, sb, sh) on top of the word-only memory.
- Sub-word stores are done as a two-cycle read-modify-write and stall the pipeline for one cycle.
- Detects misaligned accesses and captures the faulting address for the exception logic.

Parameters:
DATA_WIDTH, 32, data and address width; only 32 is supported.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
Address  input  32  byte address from the ALU
StoreData  input  32  rt value for stores
MemRead  input  1  load request
MemWrite  input  1  store request
AccessSize  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
LoadUnsigned  input  1  1 = zero-extend, 0 = sign-extend
MemReadData  input  32  word from data memory, combinational read
MemAddress  output  32  byte address to data memory
MemWriteData  output  32  word to data memory
MemWriteEn  output  1  data memory write enable
MemReadEn  output  1  data memory read enable
LoadData  output  32  extended load result to MEM/WB
Stall  output  1  freeze PC, IF/ID, ID/EX and EX/MEM
AddressError  output  1  misaligned access this cycle (combinational pulse)
ErrorFlag  output  1  sticky misalignment flag
BadAddress  output  32  address of the first misaligned access
ErrorClear  input  1  synchronous clear of ErrorFlag and BadAddress

Behaviour:
- Memory model:
  - Little-endian: lane = Address[1:0], lane 0 = bits 7:0.
  - Data memory reads combinationally and writes on the rising edge.
- Reset (asynchronous, active-low): state IDLE, ErrorFlag 0, BadAddress 0, merge and address registers 0.
- Reset outputs: MemWriteEn 0, MemReadEn 0, Stall 0, LoadData 0.
- Reset during RMW_WRITE aborts the write; memory is not modified.
- Misalignment:
  - Half with Address[0]=1, or word with Address[1:0]!=00, while MemRead or MemWrite is high.
  - AddressError=1 that cycle; MemWriteEn=0 and MemReadEn=0; LoadData=0; no state change.
  - On the next edge ErrorFlag is set and BadAddress captured, only if ErrorFlag was 0.
  - ErrorClear clears both on the next edge; ErrorClear has priority over a simultaneous new error.
- Priority: MemRead and MemWrite both high means write wins and LoadData=0.
- State IDLE:
  - Load, aligned:
    - MemReadEn=1, MemAddress=Address.
    - LoadData = selected lane, sign- or zero-extended; latency 0 cycles.
    - With MemRead=0, LoadData=0.
  - Word store, aligned: MemWriteEn=1, MemWriteData=StoreData, written at this edge; Stall=0.
  - Sub-word store, aligned:
    - MemReadEn=1, Stall=1.
    - Merged word is registered: MemReadData with the target lane(s) replaced by StoreData[7:0] or StoreData[15:0].
    - Address is latched; next state RMW_WRITE.
- State RMW_WRITE:
  - MemWriteEn=1, MemAddress = latched address, MemWriteData = merged register.
  - Stall=0; pipeline inputs are ignored; always returns to IDLE.
- Throughput:
  - Loads and word stores: 1 per cycle.
  - Sub-word stores: 1 per 2 cycles.
  - Back-to-back sb/sh: each is a separate 2-cycle RMW.
- AccessSize 11 is treated exactly as word, including the alignment check.

Decomposition:
- Package mips_mem_pkg:
  - AccessSize encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD).
  - lsu_state_t enum (IDLE, RMW_WRITE).
- Sub-module load_extender: combinational lane select plus sign/zero extension; reused by a future cache.
- Store merge stays inline.

Test Plan:
- Load extension:
  - Preload word 0 = 0x807F_1234 (bytes 34,12,7F,80). lb @0x3 -> LoadData 0xFFFFFF80.
  - lbu @0x3 -> 0x00000080; lh @0x2 -> 0xFFFF807F; lhu @0x0 -> 0x00001234.
- Byte store:
  - sb 0xAB @0x1 on word 0 = 0x11223344.
  - Cycle 1: Stall=1, MemReadEn=1, no write.
  - Cycle 2: MemWriteEn=1, MemWriteData 0x1122AB44; memory word 0 = 0x1122AB44.
- Word store: sw 0xDEADBEEF @0x8 -> single cycle, Stall=0, word 2 = 0xDEADBEEF; next-cycle lw @0x8 returns it.
- Misalignment:
  - lw @0x6 -> AddressError=1, no memory enables; next cycle ErrorFlag=1, BadAddress=0x6.
  - sh @0x3 after that -> AddressError=1, BadAddress stays 0x6.
  - ErrorClear -> ErrorFlag=0, BadAddress=0.
- Reset mid-RMW: sb 0xFF @0x0 with reset asserted during RMW_WRITE -> memory unchanged, state IDLE, Stall=0, all outputs at reset values.
- Back-to-back: sh 0xBEEF @0x2 then sb 0x55 @0x0 on word 0 = 0 -> 4 cycles total, Stall high in cycles 1 and 3, final word 0 = 0xBEEF0055.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM-stage load/store path: access sizes and LSU state.
package mips_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic {
        IDLE,
        RMW_WRITE
    } lsu_state_t;

    // Encoding 11 is reserved and behaves exactly like a word access.
    function automatic logic isWordSize(input logic [1:0] size);
        return (size == SIZE_WORD) || (size == 2'b11);
    endfunction

endpackage

// File: rtl/load_store_unit_extender.sv
// Picks the addressed byte/halfword out of a little-endian word and sign- or zero-extends it.
module load_extender
    import mips_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rdWord,
    input  logic [1:0]            lane,
    input  logic [1:0]            size,
    input  logic                  zeroExt,
    output logic [DATA_WIDTH-1:0] result
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        byteSel = rdWord[{lane, 3'b000} +: 8];
        halfSel = rdWord[{lane[1], 4'b0000} +: 16];
        result  = rdWord;
        if (size == SIZE_BYTE) begin
            result = zeroExt ? {{(DATA_WIDTH-8){1'b0}}, byteSel}
                             : {{(DATA_WIDTH-8){byteSel[7]}}, byteSel};
        end else if (size == SIZE_HALF) begin
            result = zeroExt ? {{(DATA_WIDTH-16){1'b0}}, halfSel}
                             : {{(DATA_WIDTH-16){halfSel[15]}}, halfSel};
        end else if (isWordSize(size)) begin
            result = rdWord;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: sub-word loads, read-modify-write sub-word stores and
// misalignment capture in front of a word-only data memory.
module load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] StoreData,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [1:0]            AccessSize,
    input  logic                  LoadUnsigned,
    input  logic [DATA_WIDTH-1:0] MemReadData,
    output logic [DATA_WIDTH-1:0] MemAddress,
    output logic [DATA_WIDTH-1:0] MemWriteData,
    output logic                  MemWriteEn,
    output logic                  MemReadEn,
    output logic [DATA_WIDTH-1:0] LoadData,
    output logic                  Stall,
    output logic                  AddressError,
    output logic                  ErrorFlag,
    output logic [DATA_WIDTH-1:0] BadAddress,
    input  logic                  ErrorClear
);

    lsu_state_t            state;
    logic [DATA_WIDTH-1:0] rmwAddr_p1;
    logic [DATA_WIDTH-1:0] mergeWord_p1;
    logic [DATA_WIDTH-1:0] extData;
    logic                  isByte;
    logic                  isHalf;
    logic                  isWord;
    logic                  misaligned;
    logic                  subWordStore;

    function automatic logic [DATA_WIDTH-1:0] mergeStore(
        input logic [DATA_WIDTH-1:0] memWord,
        input logic [DATA_WIDTH-1:0] data,
        input logic [1:0]            lane,
        input logic                  byteAccess
    );
        logic [DATA_WIDTH-1:0] merged;
        merged = memWord;
        if (byteAccess) begin
            merged[{lane, 3'b000} +: 8] = data[7:0];
        end else begin
            merged[{lane[1], 4'b0000} +: 16] = data[15:0];
        end
        return merged;
    endfunction

    load_extender #(
        .DATA_WIDTH(DATA_WIDTH)
    ) uExtender (
        .rdWord (MemReadData),
        .lane   (Address[1:0]),
        .size   (AccessSize),
        .zeroExt(LoadUnsigned),
        .result (extData)
    );

    // Pipeline inputs are only decoded in IDLE; during RMW_WRITE they are ignored.
    always_comb begin
        isByte       = (AccessSize == SIZE_BYTE);
        isHalf       = (AccessSize == SIZE_HALF);
        isWord       = isWordSize(AccessSize);
        misaligned   = (state == IDLE) && (MemRead || MemWrite) &&
                       ((isHalf && Address[0]) || (isWord && (Address[1:0] != 2'b00)));
        subWordStore = (state == IDLE) && MemWrite && !misaligned && !isWord;
    end

    // Outputs are forced to their idle values while reset is held, which also aborts a pending write.
    always_comb begin
        MemAddress   = Address;
        MemWriteData = '0;
        MemWriteEn   = 1'b0;
        MemReadEn    = 1'b0;
        LoadData     = '0;
        Stall        = 1'b0;
        AddressError = 1'b0;
        if (reset) begin
            if (state == RMW_WRITE) begin
                MemAddress   = rmwAddr_p1;
                MemWriteData = mergeWord_p1;
                MemWriteEn   = 1'b1;
            end else if (misaligned) begin
                AddressError = 1'b1;
            end else if (MemWrite) begin
                if (isWord) begin
                    MemWriteEn   = 1'b1;
                    MemWriteData = StoreData;
                end else begin
                    MemReadEn = 1'b1;
                    Stall     = 1'b1;
                end
            end else if (MemRead) begin
                MemReadEn = 1'b1;
                LoadData  = extData;
            end
        end
    end

    // Stage p0 -> p1: merged word and address held for the write half of the RMW.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            rmwAddr_p1   <= '0;
            mergeWord_p1 <= '0;
            ErrorFlag    <= 1'b0;
            BadAddress   <= '0;
        end else begin
            if (state == IDLE) begin
                if (subWordStore) begin
                    mergeWord_p1 <= mergeStore(MemReadData, StoreData, Address[1:0], isByte);
                    rmwAddr_p1   <= Address;
                    state        <= RMW_WRITE;
                end
            end else begin
                state <= IDLE;
            end

            // Only the first fault is kept until software acknowledges it.
            if (ErrorClear) begin
                ErrorFlag  <= 1'b0;
                BadAddress <= '0;
            end else if (misaligned && !ErrorFlag) begin
                ErrorFlag  <= 1'b1;
                BadAddress <= Address;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word memory model plus load/write scoreboards.
module tb_load_store_unit;
    import mips_mem_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wrExp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address, StoreData, MemReadData, MemAddress, MemWriteData;
    logic        MemRead, MemWrite, LoadUnsigned, ErrorClear;
    logic [1:0]  AccessSize;
    logic        MemWriteEn, MemReadEn, Stall, AddressError, ErrorFlag;
    logic [31:0] LoadData, BadAddress;

    logic [31:0] mem [0:15];
    logic        preEn = 1'b0;
    logic [3:0]  preIdx = '0;
    logic [31:0] preData = '0;

    logic [31:0] ldQ[$];
    wrExp_t      wrQ[$];
    int          nChecks = 0;
    int          nFails = 0;

    load_store_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .Address(Address), .StoreData(StoreData),
        .MemRead(MemRead), .MemWrite(MemWrite), .AccessSize(AccessSize),
        .LoadUnsigned(LoadUnsigned), .MemReadData(MemReadData),
        .MemAddress(MemAddress), .MemWriteData(MemWriteData),
        .MemWriteEn(MemWriteEn), .MemReadEn(MemReadEn), .LoadData(LoadData),
        .Stall(Stall), .AddressError(AddressError), .ErrorFlag(ErrorFlag),
        .BadAddress(BadAddress), .ErrorClear(ErrorClear)
    );

    always #5 clk = ~clk;

    assign MemReadData = mem[MemAddress[5:2]];

    always @(posedge clk) begin
        if (MemWriteEn) mem[MemAddress[5:2]] <= MemWriteData;
        else if (preEn) mem[preIdx] <= preData;
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard consumers: every memory write and every accepted load pops one expectation.
    always @(negedge clk) begin
        wrExp_t e;
        if (MemWriteEn) begin
            if (wrQ.size() == 0) begin
                checkVal("wr_unexpected", 32'd1, 32'd0);
            end else begin
                e = wrQ.pop_front();
                checkVal("wr_addr", {MemAddress[31:2], 2'b00}, {e.addr[31:2], 2'b00});
                checkVal("wr_data", MemWriteData, e.data);
            end
        end
        if (MemRead && !MemWrite && MemReadEn) begin
            if (ldQ.size() == 0) checkVal("ld_unexpected", 32'd1, 32'd0);
            else checkVal("ld_data", LoadData, ldQ.pop_front());
        end
    end

    task automatic idleIn();
        Address = '0; StoreData = '0; MemRead = 1'b0; MemWrite = 1'b0;
        AccessSize = 2'b10; LoadUnsigned = 1'b0; ErrorClear = 1'b0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] val);
        preEn = 1'b1; preIdx = idx; preData = val;
        nextCycle();
        preEn = 1'b0;
    endtask

    task automatic doLoad(input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] exp);
        Address = addr; AccessSize = size; LoadUnsigned = uns; MemRead = 1'b1;
        ldQ.push_back(exp);
        @(negedge clk);
        checkVal("ld_readen", {31'd0, MemReadEn}, 32'd1);
        nextCycle();
        idleIn();
    endtask

    task automatic doWordStore(input logic [31:0] addr, input logic [31:0] data);
        Address = addr; StoreData = data; AccessSize = SIZE_WORD; MemWrite = 1'b1;
        wrQ.push_back('{addr: addr, data: data});
        @(negedge clk);
        checkVal("sw_stall", {31'd0, Stall}, 32'd0);
        nextCycle();
        idleIn();
    endtask

    task automatic doSubStore(input logic [31:0] addr, input logic [31:0] data,
                              input logic [1:0] size, input logic [31:0] merged);
        Address = addr; StoreData = data; AccessSize = size; MemWrite = 1'b1;
        wrQ.push_back('{addr: addr, data: merged});
        @(negedge clk);
        checkVal("rmw1_stall", {31'd0, Stall}, 32'd1);
        checkVal("rmw1_readen", {31'd0, MemReadEn}, 32'd1);
        checkVal("rmw1_writeen", {31'd0, MemWriteEn}, 32'd0);
        nextCycle();
        @(negedge clk);
        checkVal("rmw2_stall", {31'd0, Stall}, 32'd0);
        checkVal("rmw2_writeen", {31'd0, MemWriteEn}, 32'd1);
        nextCycle();
        idleIn();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        idleIn();
        reset = 1'b0;
        MemRead = 1'b1;
        #12;
        checkVal("rst_writeen", {31'd0, MemWriteEn}, 32'd0);
        checkVal("rst_readen", {31'd0, MemReadEn}, 32'd0);
        checkVal("rst_stall", {31'd0, Stall}, 32'd0);
        checkVal("rst_loaddata", LoadData, 32'd0);
        checkVal("rst_errflag", {31'd0, ErrorFlag}, 32'd0);
        checkVal("rst_badaddr", BadAddress, 32'd0);
        idleIn();
        reset = 1'b1;
        nextCycle();

        // Load extension
        preload(4'd0, 32'h807F_1234);
        doLoad(32'h3, SIZE_BYTE, 1'b0, 32'hFFFF_FF80);
        doLoad(32'h3, SIZE_BYTE, 1'b1, 32'h0000_0080);
        doLoad(32'h2, SIZE_HALF, 1'b0, 32'hFFFF_807F);
        doLoad(32'h0, SIZE_HALF, 1'b1, 32'h0000_1234);
        doLoad(32'h1, SIZE_BYTE, 1'b0, 32'h0000_0012);
        doLoad(32'h0, SIZE_WORD, 1'b0, 32'h807F_1234);
        doLoad(32'h0, 2'b11, 1'b1, 32'h807F_1234);
        @(negedge clk);
        checkVal("noread_loaddata", LoadData, 32'd0);
        nextCycle();

        // Byte store read-modify-write
        preload(4'd0, 32'h1122_3344);
        doSubStore(32'h1, 32'h0000_00AB, SIZE_BYTE, 32'h1122_AB44);
        checkVal("sb_mem", mem[0], 32'h1122_AB44);
        doLoad(32'h0, SIZE_WORD, 1'b0, 32'h1122_AB44);

        // Word store then load back
        doWordStore(32'h8, 32'hDEAD_BEEF);
        doLoad(32'h8, SIZE_WORD, 1'b0, 32'hDEAD_BEEF);

        // Misalignment capture
        Address = 32'h6; AccessSize = SIZE_WORD; MemRead = 1'b1;
        @(negedge clk);
        checkVal("mis_adderr", {31'd0, AddressError}, 32'd1);
        checkVal("mis_readen", {31'd0, MemReadEn}, 32'd0);
        checkVal("mis_writeen", {31'd0, MemWriteEn}, 32'd0);
        checkVal("mis_loaddata", LoadData, 32'd0);
        nextCycle();
        idleIn();
        @(negedge clk);
        checkVal("mis_flag", {31'd0, ErrorFlag}, 32'd1);
        checkVal("mis_badaddr", BadAddress, 32'h6);
        checkVal("mis_pulse_gone", {31'd0, AddressError}, 32'd0);
        nextCycle();
        Address = 32'h3; AccessSize = SIZE_HALF; MemWrite = 1'b1; StoreData = 32'h1111;
        @(negedge clk);
        checkVal("mis2_adderr", {31'd0, AddressError}, 32'd1);
        checkVal("mis2_stall", {31'd0, Stall}, 32'd0);
        checkVal("mis2_readen", {31'd0, MemReadEn}, 32'd0);
        nextCycle();
        idleIn();
        @(negedge clk);
        checkVal("mis2_badaddr_kept", BadAddress, 32'h6);
        nextCycle();
        ErrorClear = 1'b1; Address = 32'h5; AccessSize = SIZE_WORD; MemRead = 1'b1;
        nextCycle();
        idleIn();
        @(negedge clk);
        checkVal("clr_flag", {31'd0, ErrorFlag}, 32'd0);
        checkVal("clr_badaddr", BadAddress, 32'd0);
        nextCycle();
        Address = 32'hA; AccessSize = 2'b11; MemRead = 1'b1;
        @(negedge clk);
        checkVal("mis3_adderr", {31'd0, AddressError}, 32'd1);
        nextCycle();
        idleIn();
        @(negedge clk);
        checkVal("mis3_badaddr", BadAddress, 32'hA);
        nextCycle();
        ErrorClear = 1'b1;
        nextCycle();
        idleIn();

        // Read and write together: write wins
        Address = 32'hC; StoreData = 32'h0BAD_F00D; AccessSize = SIZE_WORD;
        MemRead = 1'b1; MemWrite = 1'b1;
        wrQ.push_back('{addr: 32'hC, data: 32'h0BAD_F00D});
        @(negedge clk);
        checkVal("both_loaddata", LoadData, 32'd0);
        checkVal("both_writeen", {31'd0, MemWriteEn}, 32'd1);
        nextCycle();
        idleIn();
        doLoad(32'hC, SIZE_WORD, 1'b0, 32'h0BAD_F00D);

        // Reset asserted during the write half of an RMW
        preload(4'd0, 32'hCAFE_F00D);
        Address = 32'h0; StoreData = 32'hFF; AccessSize = SIZE_BYTE; MemWrite = 1'b1;
        @(negedge clk);
        checkVal("rr_stall1", {31'd0, Stall}, 32'd1);
        nextCycle();
        reset = 1'b0;
        @(negedge clk);
        checkVal("rr_writeen", {31'd0, MemWriteEn}, 32'd0);
        checkVal("rr_readen", {31'd0, MemReadEn}, 32'd0);
        checkVal("rr_stall", {31'd0, Stall}, 32'd0);
        checkVal("rr_loaddata", LoadData, 32'd0);
        #1;
        idleIn();
        reset = 1'b1;
        nextCycle();
        @(negedge clk);
        checkVal("rr_idle_stall", {31'd0, Stall}, 32'd0);
        checkVal("rr_idle_writeen", {31'd0, MemWriteEn}, 32'd0);
        checkVal("rr_mem", mem[0], 32'hCAFE_F00D);
        nextCycle();

        // Back-to-back sub-word stores
        preload(4'd0, 32'h0);
        doSubStore(32'h2, 32'h0000_BEEF, SIZE_HALF, 32'hBEEF_0000);
        doSubStore(32'h0, 32'h0000_0055, SIZE_BYTE, 32'hBEEF_0055);
        checkVal("b2b_mem", mem[0], 32'hBEEF_0055);

        nextCycle();
        checkVal("ldq_empty", ldQ.size(), 32'd0);
        checkVal("wrq_empty", wrQ.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
